// File: rtl/game_pkg.sv
// Shared types and timing constants for the penalty-shootout match sequencer.
package game_pkg;

  // Externally visible game phase driven to the shooter/keeper control chain.
  typedef enum logic [2:0] {
    START   = 3'd0,
    SHOOTER = 3'd1,
    KEEPER  = 3'd2,
    WINNER  = 3'd3,
    LOSER   = 3'd4
  } g_state;

  // Internal round sequencer states.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SHOOT_GO   = 4'd1,
    S_SHOOT_WAIT = 4'd2,
    S_CHECK_S    = 4'd3,
    S_KEEP_GO    = 4'd4,
    S_KEEP_WAIT  = 4'd5,
    S_CHECK_K    = 4'd6,
    S_END_WIN    = 4'd7,
    S_END_LOSE   = 4'd8
  } seq_state_t;

  localparam int unsigned CYCLES_PER_SEC   = 65_019_506;
  localparam int unsigned KICK_TIMEOUT_DEF = 2 * CYCLES_PER_SEC;
  localparam int unsigned END_HOLD_DEF     = 3 * CYCLES_PER_SEC;
  localparam int unsigned TIMER_W          = 28;

  // Goal counter increment that sticks at 7.
  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic inc);
    return (inc && (v != 3'd7)) ? v + 3'd1 : v;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector; history resets high so a level held
// through reset does not produce an edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_hist;
  logic r_rise;

  // Track previous level and register the rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 1'b1;
      r_rise <= 1'b0;
    end else begin
      r_hist <= i_sig;
      r_rise <= i_sig & ~r_hist;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/match_sequencer.sv
// Penalty-shootout round scheduler: issues kicks to the shooter/keeper chain,
// collects results, keeps scores and round count, and decides the match.
module match_sequencer
  import game_pkg::*;
#(
  parameter int unsigned ROUNDS       = 5,
  parameter int unsigned MAX_ROUNDS   = 15,
  parameter int unsigned KICK_TIMEOUT = KICK_TIMEOUT_DEF,
  parameter int unsigned END_HOLD     = END_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       kick_done,
  input  logic       is_scored,
  output g_state     game_state,
  output logic       kick_start,
  output logic [3:0] round_counter,
  output logic [2:0] score_player,
  output logic [2:0] score_opp
);

  localparam logic [4:0]         ROUNDS5   = 5'(ROUNDS);
  localparam logic [4:0]         MAX5      = 5'(MAX_ROUNDS);
  localparam logic [TIMER_W-1:0] KICK_LAST = TIMER_W'(KICK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] END_LAST  = TIMER_W'(END_HOLD - 1);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               r_scored;
  logic               w_scored_nxt;
  logic [2:0]         r_score_p;
  logic [2:0]         w_score_p_nxt;
  logic [2:0]         r_score_o;
  logic [2:0]         w_score_o_nxt;
  logic [3:0]         r_round;
  logic [3:0]         w_round_nxt;
  g_state             r_game_state;
  g_state             w_game_state_nxt;
  logic               r_kick_start;
  logic               w_kick_start_nxt;
  logic               w_start_rise;

  // Candidate post-kick values, widened to 5 bits so score + remaining kicks cannot wrap.
  logic [2:0] w_sp_inc;
  logic [2:0] w_so_inc;
  logic [3:0] w_round_inc;
  logic [4:0] w_ps5;
  logic [4:0] w_psi5;
  logic [4:0] w_os5;
  logic [4:0] w_osi5;
  logic [4:0] w_rc5;
  logic [4:0] w_cnt5;
  logic [4:0] w_rem_s;
  logic [4:0] w_rem_k;

  edge_detect u_start_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (start),
    .o_rise (w_start_rise)
  );

  assign w_sp_inc    = sat_inc(r_score_p, r_scored);
  assign w_so_inc    = sat_inc(r_score_o, r_scored);
  assign w_round_inc = r_round + 4'd1;
  assign w_ps5       = {2'b00, r_score_p};
  assign w_psi5      = {2'b00, w_sp_inc};
  assign w_os5       = {2'b00, r_score_o};
  assign w_osi5      = {2'b00, w_so_inc};
  assign w_rc5       = {1'b0, r_round};
  assign w_cnt5      = {1'b0, w_round_inc};
  assign w_rem_s     = ROUNDS5 - w_rc5;
  assign w_rem_k     = ROUNDS5 - w_cnt5;

  // State, timer, scores and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_scored     <= 1'b0;
      r_score_p    <= '0;
      r_score_o    <= '0;
      r_round      <= '0;
      r_game_state <= START;
      r_kick_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_scored     <= w_scored_nxt;
      r_score_p    <= w_score_p_nxt;
      r_score_o    <= w_score_o_nxt;
      r_round      <= w_round_nxt;
      r_game_state <= w_game_state_nxt;
      r_kick_start <= w_kick_start_nxt;
    end
  end

  // Next-state, datapath updates and output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_scored_nxt     = r_scored;
    w_score_p_nxt    = r_score_p;
    w_score_o_nxt    = r_score_o;
    w_round_nxt      = r_round;
    w_game_state_nxt = START;
    w_kick_start_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_game_state_nxt = START;
        if (w_start_rise) begin
          w_score_p_nxt = '0;
          w_score_o_nxt = '0;
          w_round_nxt   = '0;
          w_timer_nxt   = '0;
          w_state_nxt   = S_SHOOT_GO;
        end
      end

      S_SHOOT_GO: begin
        w_game_state_nxt = SHOOTER;
        w_kick_start_nxt = 1'b1;
        w_timer_nxt      = '0;
        w_state_nxt      = S_SHOOT_WAIT;
      end

      S_SHOOT_WAIT: begin
        w_game_state_nxt = SHOOTER;
        w_timer_nxt      = r_timer + TIMER_W'(1);
        if (kick_done) begin
          w_scored_nxt = is_scored;
          w_state_nxt  = S_CHECK_S;
        end else if (r_timer == KICK_LAST) begin
          w_scored_nxt = 1'b0;
          w_state_nxt  = S_CHECK_S;
        end
      end

      // Early end is judged on the score including this kick; opponent still has one more kick than player.
      S_CHECK_S: begin
        w_game_state_nxt = SHOOTER;
        w_score_p_nxt    = w_sp_inc;
        w_timer_nxt      = '0;
        w_state_nxt      = S_KEEP_GO;
        if (w_rc5 < ROUNDS5) begin
          if (w_psi5 > w_os5 + w_rem_s) begin
            w_state_nxt = S_END_WIN;
          end else if (w_os5 > w_psi5 + (w_rem_s - 5'd1)) begin
            w_state_nxt = S_END_LOSE;
          end
        end
      end

      S_KEEP_GO: begin
        w_game_state_nxt = KEEPER;
        w_kick_start_nxt = 1'b1;
        w_timer_nxt      = '0;
        w_state_nxt      = S_KEEP_WAIT;
      end

      S_KEEP_WAIT: begin
        w_game_state_nxt = KEEPER;
        w_timer_nxt      = r_timer + TIMER_W'(1);
        if (kick_done) begin
          w_scored_nxt = is_scored;
          w_state_nxt  = S_CHECK_K;
        end else if (r_timer == KICK_LAST) begin
          w_scored_nxt = 1'b1;
          w_state_nxt  = S_CHECK_K;
        end
      end

      // Pair complete: regulation uses remaining kicks; sudden death needs a lead, ties at the cap go to the keeper side.
      S_CHECK_K: begin
        w_game_state_nxt = KEEPER;
        w_score_o_nxt    = w_so_inc;
        w_round_nxt      = w_round_inc;
        w_timer_nxt      = '0;
        w_state_nxt      = S_SHOOT_GO;
        if (w_cnt5 <= ROUNDS5) begin
          if (w_ps5 > w_osi5 + w_rem_k) begin
            w_state_nxt = S_END_WIN;
          end else if (w_osi5 > w_ps5 + w_rem_k) begin
            w_state_nxt = S_END_LOSE;
          end
        end else begin
          if (w_ps5 > w_osi5) begin
            w_state_nxt = S_END_WIN;
          end else if (w_osi5 > w_ps5) begin
            w_state_nxt = S_END_LOSE;
          end else if (w_cnt5 == MAX5) begin
            w_state_nxt = S_END_LOSE;
          end
        end
      end

      S_END_WIN, S_END_LOSE: begin
        w_game_state_nxt = (r_state == S_END_WIN) ? WINNER : LOSER;
        w_timer_nxt      = r_timer + TIMER_W'(1);
        if (r_timer == END_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign game_state    = r_game_state;
  assign kick_start    = r_kick_start;
  assign round_counter = r_round;
  assign score_player  = r_score_p;
  assign score_opp     = r_score_o;

endmodule

// File: tb/tb_match_sequencer.sv
// Randomized self-checking bench for match_sequencer against a kick-count
// shootout model.
module tb_match_sequencer;
  import game_pkg::*;

  localparam int unsigned KT = 20;
  localparam int unsigned EH = 10;
  localparam int unsigned NR = 5;
  localparam int unsigned MR = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       kick_done;
  logic       is_scored;
  g_state     game_state;
  logic       kick_start;
  logic [3:0] round_counter;
  logic [2:0] score_player;
  logic [2:0] score_opp;

  int n_total = 0;
  int n_bad   = 0;

  // Shootout model: goals and kicks taken by each side.
  int m_p, m_o, m_pk, m_ok;
  bit m_over, m_win;

  int end_run      = 0;
  int last_end_run = 0;

  always #5 clk = ~clk;

  match_sequencer #(
    .ROUNDS       (NR),
    .MAX_ROUNDS   (MR),
    .KICK_TIMEOUT (KT),
    .END_HOLD     (EH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .kick_done     (kick_done),
    .is_scored     (is_scored),
    .game_state    (game_state),
    .kick_start    (kick_start),
    .round_counter (round_counter),
    .score_player  (score_player),
    .score_opp     (score_opp)
  );

  // Length of each contiguous WINNER/LOSER display.
  always @(negedge clk) begin
    if (game_state == WINNER || game_state == LOSER) begin
      end_run++;
    end else begin
      if (end_run != 0) last_end_run = end_run;
      end_run = 0;
    end
  end

  task automatic chk(input string tag, input int obs, input int want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic model_clear();
    m_p = 0; m_o = 0; m_pk = 0; m_ok = 0; m_over = 0; m_win = 0;
  endtask

  // Apply one kick to the model and decide whether the match is settled.
  task automatic model_kick(input bit side, input bit goal);
    int rp, ro;
    if (side) begin
      m_pk++;
      if (goal && m_p < 7) m_p++;
    end else begin
      m_ok++;
      if (goal && m_o < 7) m_o++;
    end
    if (m_pk <= NR && m_ok <= NR) begin
      rp = NR - m_pk;
      ro = NR - m_ok;
      if (m_p > m_o + ro) begin
        m_over = 1; m_win = 1;
      end else if (m_o > m_p + rp) begin
        m_over = 1; m_win = 0;
      end
    end else if (m_pk == m_ok) begin
      if (m_p != m_o) begin
        m_over = 1; m_win = (m_p > m_o);
      end else if (m_ok == MR) begin
        m_over = 1; m_win = 0;
      end
    end
  endtask

  task automatic wait_kick(input bit side, output bit ok);
    int n = 0;
    while (kick_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("kick_seen", int'(kick_start), 1);
    ok = (kick_start === 1'b1);
    if (ok) begin
      chk("kick_side", int'(game_state), side ? int'(SHOOTER) : int'(KEEPER));
      chk("kick_sp", int'(score_player), m_p);
      chk("kick_so", int'(score_opp), m_o);
      chk("kick_rc", int'(round_counter), m_ok);
    end
  endtask

  // delay<0: no kick_done (timeout); stray: keep kick_done high into CHECK/GO with is_scored=1.
  task automatic do_kick(input bit side, input int delay, input bit goal, input bit stray,
                         output bit ok);
    wait_kick(side, ok);
    if (!ok) return;
    if (delay < 0) begin
      @(negedge clk);
    end else begin
      for (int j = 0; j < delay; j++) begin
        @(negedge clk);
        if (j == 0) chk("ks_pulse", int'(kick_start), 0);
      end
      kick_done = 1'b1;
      is_scored = goal;
      @(negedge clk);
      if (stray) begin
        is_scored = 1'b1;
        repeat (2) @(negedge clk);
      end
      kick_done = 1'b0;
      is_scored = 1'($urandom);
    end
  endtask

  task automatic choose(input int pol, input bit side, output int delay, output bit goal,
                        output bit stray);
    int r;
    delay = int'($urandom_range(0, 5));
    goal  = 1'($urandom);
    stray = 1'b0;
    case (pol)
      1: goal = side;
      2: delay = -1;
      3: goal = 1'b1;
      4: goal = (m_ok == 5) ? !side : 1'b1;
      5: if (side && m_pk == 0) begin
           delay = KT - 1; goal = 1'b1; stray = 1'b1;
         end
      default: begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      delay = -1;
        else if (r == 1) delay = KT - 1;
        else             delay = int'($urandom_range(0, KT - 2));
        stray = ($urandom_range(0, 3) == 0);
      end
    endcase
    if (delay < 0) goal = !side;
  endtask

  task automatic run_match(input int pol);
    int n, delay, kicks;
    bit side, goal, stray, ok;
    n = 0;
    while (game_state !== START && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_start", int'(game_state), int'(START));
    start = 1'b0;
    kick_done = 1'b1;
    is_scored = 1'b1;
    @(negedge clk);
    kick_done = 1'b0;
    @(negedge clk);
    chk("idle_sp", int'(score_player), m_p);
    chk("idle_so", int'(score_opp), m_o);
    model_clear();
    last_end_run = 0;
    start = 1'b1;
    kicks = 0;
    while (!m_over && kicks < 40) begin
      side = (m_pk == m_ok);
      choose(pol, side, delay, goal, stray);
      do_kick(side, delay, goal, stray, ok);
      if (!ok) return;
      model_kick(side, goal);
      kicks++;
    end
    n = 0;
    while (!(game_state == WINNER || game_state == LOSER) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("end_state", int'(game_state), m_win ? int'(WINNER) : int'(LOSER));
    chk("end_sp", int'(score_player), m_p);
    chk("end_so", int'(score_opp), m_o);
    chk("end_rc", int'(round_counter), m_ok);
    n = 0;
    while (game_state !== START && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("end_hold", last_end_run, EH);
    chk("after_state", int'(game_state), int'(START));
    chk("after_sp", int'(score_player), m_p);
    chk("after_so", int'(score_opp), m_o);
  endtask

  task automatic reset_mid_match();
    bit ok;
    int ks_cnt;
    start = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    start = 1'b1;
    do_kick(1'b1, 1, 1'b1, 1'b0, ok);
    if (!ok) return;
    model_kick(1'b1, 1'b1);
    do_kick(1'b0, 3, 1'b1, 1'b0, ok);
    if (!ok) return;
    model_kick(1'b0, 1'b1);
    do_kick(1'b1, 0, 1'b1, 1'b0, ok);
    if (!ok) return;
    model_kick(1'b1, 1'b1);
    wait_kick(1'b0, ok);
    if (!ok) return;
    rst = 1'b1;
    kick_done = 1'b1;
    is_scored = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    kick_done = 1'b0;
    chk("rst_state", int'(game_state), int'(START));
    chk("rst_ks", int'(kick_start), 0);
    chk("rst_rc", int'(round_counter), 0);
    chk("rst_sp", int'(score_player), 0);
    chk("rst_so", int'(score_opp), 0);
    ks_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (kick_start === 1'b1 || game_state !== START) ks_cnt++;
    end
    chk("no_false_start", ks_cnt, 0);
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b1;
    kick_done = 1'b0;
    is_scored = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", int'(game_state), int'(START));
    chk("reset_ks", int'(kick_start), 0);
    chk("reset_rc", int'(round_counter), 0);
    chk("reset_sp", int'(score_player), 0);
    chk("reset_so", int'(score_opp), 0);

    run_match(1);
    run_match(2);
    run_match(3);
    run_match(4);
    run_match(5);
    reset_mid_match();
    for (int i = 0; i < 10; i++) run_match(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
